// File: rtl/fuzzy_host_pkg.sv
// rtl/fuzzy_host_pkg.sv - shared types and constants for the fuzzy host sequencer
package fuzzy_host_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SETTLE = 2'd2,
      OUT    = 2'd3
   } state_t;

   localparam logic [7:0] ZERO_OFFSET = 8'd128;
   localparam int         ERR_W       = 10;
   localparam int         DLT_W       = 11;

endpackage

// File: rtl/fuzzy_sat8.sv
// rtl/fuzzy_sat8.sv - signed value plus zero offset, clamped to 0..255
module fuzzy_sat8
   import fuzzy_host_pkg::*;
#(
   parameter int W = ERR_W
) (
   input  logic signed [W-1:0] val_i,
   output logic [7:0]          sat_o
);

   logic [W:0] sum;

   // Range never overflows W+1 bits, so the top bit is the true sign.
   always_comb begin
      sum = {val_i[W-1], val_i} + {{(W-7){1'b0}}, ZERO_OFFSET};
      if (sum[W]) begin
         sat_o = 8'd0;
      end else if (sum[W-1:8] != '0) begin
         sat_o = 8'd255;
      end else begin
         sat_o = sum[7:0];
      end
   end

endmodule

// File: rtl/fuzzy_host_seq.sv
// rtl/fuzzy_host_seq.sv - measurement-to-control sequencer around the fuzzy core
module fuzzy_host_seq
   import fuzzy_host_pkg::*;
#(
   parameter int RULE_CYCLES   = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk_0,
   input  logic       Srst,
   input  logic [7:0] setpoint,
   input  logic [7:0] medida,
   input  logic       medida_valid,
   output logic       medida_ready,
   output logic [7:0] Entrada_01,
   output logic [7:0] Entrada_02,
   output logic       EN_REGRAS,
   input  logic [7:0] saida_defuzzy,
   output logic [7:0] controle,
   output logic       controle_valid,
   input  logic       controle_ready,
   output logic       busy
);

   localparam int MAXC = (RULE_CYCLES > SETTLE_CYCLES) ? RULE_CYCLES : SETTLE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] RULE_LAST   = CW'(RULE_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic signed [ERR_W-1:0]  e_prev_q, e_prev_d;
   logic                     first_q, first_d;
   logic [7:0]               ent1_q, ent1_d, ent2_q, ent2_d, ctl_q, ctl_d;
   logic                     en_q, en_d, cv_q, cv_d;
   logic signed [ERR_W-1:0]  err;
   logic signed [DLT_W-1:0]  dlt;
   logic [7:0]               sat_err, sat_dlt;

   assign err = $signed({2'b00, setpoint}) - $signed({2'b00, medida});
   assign dlt = {err[ERR_W-1], err} - {e_prev_q[ERR_W-1], e_prev_q};

   fuzzy_sat8 #(.W(ERR_W)) u_sat_err (.val_i(err), .sat_o(sat_err));
   fuzzy_sat8 #(.W(DLT_W)) u_sat_dlt (.val_i(dlt), .sat_o(sat_dlt));

   assign medida_ready   = (state_q == IDLE) && !Srst;
   assign busy           = (state_q != IDLE);
   assign Entrada_01     = ent1_q;
   assign Entrada_02     = ent2_q;
   assign EN_REGRAS      = en_q;
   assign controle       = ctl_q;
   assign controle_valid = cv_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      e_prev_d = e_prev_q;
      first_d  = first_q;
      ent1_d   = ent1_q;
      ent2_d   = ent2_q;
      ctl_d    = ctl_q;
      case (state_q)
         IDLE: begin
            if (medida_valid && medida_ready) begin
               state_d  = RUN;
               cnt_d    = '0;
               e_prev_d = err;
               first_d  = 1'b0;
               ent1_d   = sat_err;
               ent2_d   = first_q ? ZERO_OFFSET : sat_dlt;
            end
         end
         RUN: begin
            if (cnt_q == RULE_LAST) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = OUT;
               cnt_d   = '0;
               ctl_d   = saida_defuzzy;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         OUT: begin
            if (controle_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Outputs are decoded from the next state so they are clean flop outputs.
      en_d = (state_d == RUN);
      cv_d = (state_d == OUT);
   end

   always_ff @(posedge clk_0) begin
      if (Srst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         e_prev_q <= '0;
         first_q  <= 1'b1;
         ent1_q   <= ZERO_OFFSET;
         ent2_q   <= ZERO_OFFSET;
         ctl_q    <= 8'd0;
         en_q     <= 1'b0;
         cv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         e_prev_q <= e_prev_d;
         first_q  <= first_d;
         ent1_q   <= ent1_d;
         ent2_q   <= ent2_d;
         ctl_q    <= ctl_d;
         en_q     <= en_d;
         cv_q     <= cv_d;
      end
   end

endmodule

// File: tb/tb_fuzzy_host_seq.sv
// tb/tb_fuzzy_host_seq.sv - directed self-checking bench for fuzzy_host_seq
module tb_fuzzy_host_seq;

   logic       clk_0 = 1'b0;
   logic       Srst = 1'b1;
   logic [7:0] setpoint = 8'd0;
   logic [7:0] medida = 8'd0;
   logic       medida_valid = 1'b0;
   logic       medida_ready;
   logic [7:0] Entrada_01, Entrada_02;
   logic       EN_REGRAS;
   logic [7:0] saida_defuzzy = 8'd0;
   logic [7:0] controle;
   logic       controle_valid;
   logic       controle_ready = 1'b0;
   logic       busy;

   int errors = 0;
   int checks = 0;

   fuzzy_host_seq #(.RULE_CYCLES(16), .SETTLE_CYCLES(2)) dut (
      .clk_0         (clk_0),
      .Srst          (Srst),
      .setpoint      (setpoint),
      .medida        (medida),
      .medida_valid  (medida_valid),
      .medida_ready  (medida_ready),
      .Entrada_01    (Entrada_01),
      .Entrada_02    (Entrada_02),
      .EN_REGRAS     (EN_REGRAS),
      .saida_defuzzy (saida_defuzzy),
      .controle      (controle),
      .controle_valid(controle_valid),
      .controle_ready(controle_ready),
      .busy          (busy)
   );

   always #5 clk_0 = ~clk_0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_0);
      #1;
   endtask

   // One full sample: accept, observe rule sweep and latency, optional backpressure, handshake.
   task automatic run_sample(input string tag, input int sp, input int md, input int core,
                             input int exp_e1, input int exp_e2, input int hold);
      int n, en_cnt, bound;
      setpoint      = 8'(sp);
      medida        = 8'(md);
      saida_defuzzy = 8'(core);
      medida_valid  = 1'b1;
      bound = 0;
      while (!medida_ready && bound < 50) begin
         step();
         bound++;
      end
      chk({tag, "_ready"}, int'(medida_ready), 1);
      step();
      medida_valid = 1'b0;
      chk({tag, "_e1"}, int'(Entrada_01), exp_e1);
      chk({tag, "_e2"}, int'(Entrada_02), exp_e2);
      n = 1;
      en_cnt = 0;
      while (!controle_valid && n < 100) begin
         if (EN_REGRAS) en_cnt++;
         step();
         n++;
      end
      chk({tag, "_en_cycles"}, en_cnt, 16);
      chk({tag, "_latency"}, n, 19);
      chk({tag, "_controle"}, int'(controle), core);
      for (int i = 0; i < hold; i++) begin
         medida_valid  = 1'b1;
         setpoint      = 8'd7;
         medida        = 8'd200;
         saida_defuzzy = 8'hEE;
         step();
         chk({tag, "_bp_valid"}, int'(controle_valid), 1);
         chk({tag, "_bp_ctl"}, int'(controle), core);
         chk({tag, "_bp_mready"}, int'(medida_ready), 0);
         chk({tag, "_bp_e1"}, int'(Entrada_01), exp_e1);
      end
      controle_ready = 1'b1;
      chk({tag, "_hs_mready"}, int'(medida_ready), 0);
      step();
      controle_ready = 1'b0;
      chk({tag, "_post_valid"}, int'(controle_valid), 0);
      chk({tag, "_post_mready"}, int'(medida_ready), 1);
      chk({tag, "_post_busy"}, int'(busy), 0);
   endtask

   initial begin
      int seen_cv;
      Srst = 1'b1;
      repeat (3) step();
      chk("rst_mready", int'(medida_ready), 0);
      chk("rst_en", int'(EN_REGRAS), 0);
      chk("rst_cv", int'(controle_valid), 0);
      chk("rst_ctl", int'(controle), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_e1", int'(Entrada_01), 128);
      chk("rst_e2", int'(Entrada_02), 128);
      Srst = 1'b0;
      step();
      chk("rel_mready", int'(medida_ready), 1);
      chk("rel_e1", int'(Entrada_01), 128);
      chk("rel_e2", int'(Entrada_02), 128);

      run_sample("s1", 100, 60, 8'h5A, 168, 128, 0);
      run_sample("s2", 100, 90, 8'h33, 138, 98, 0);
      run_sample("sat_hi", 255, 0, 8'h11, 255, 255, 0);
      run_sample("sat_lo", 0, 255, 8'h22, 0, 0, 5);
      // Backpressure sample left medida_valid high; acceptance follows immediately.
      run_sample("after_bp", 128, 128, 8'h44, 128, 255, 0);

      setpoint     = 8'd50;
      medida       = 8'd20;
      medida_valid = 1'b1;
      step();
      medida_valid = 1'b0;
      chk("mid_en_c1", int'(EN_REGRAS), 1);
      repeat (4) step();
      chk("mid_en_c5", int'(EN_REGRAS), 1);
      Srst = 1'b1;
      step();
      chk("mid_rst_en", int'(EN_REGRAS), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_cv", int'(controle_valid), 0);
      chk("mid_rst_ctl", int'(controle), 0);
      chk("mid_rst_e1", int'(Entrada_01), 128);
      chk("mid_rst_mready", int'(medida_ready), 0);
      Srst = 1'b0;
      seen_cv = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (controle_valid) seen_cv = 1;
      end
      chk("mid_no_cv", seen_cv, 0);
      run_sample("post_rst", 100, 90, 8'h77, 138, 128, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
